// File: rtl/kbd_map_pkg.sv
// Shared types and constants for the PS/2 set-2 keyboard to joystick mapper:
// decoder states, joystick bit positions, prefix scan codes and the key table.
package kbd_map_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXTBRK,
        ST_SKIP
    } dec_state_e;

    localparam int FIRE1 = 0;
    localparam int FIRE2 = 1;
    localparam int START = 2;
    localparam int COIN  = 3;
    localparam int UP    = 4;
    localparam int DOWN  = 5;
    localparam int LEFT  = 6;
    localparam int RIGHT = 7;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    // Bytes still to swallow after the E1 that opens the Pause sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Entry [player][bit] = {extended, code}, ordered by joystick bit index
    localparam logic [8:0] KEY_TABLE [2][8] = '{
        '{9'h029, 9'h011, 9'h016, 9'h02E, 9'h175, 9'h172, 9'h16B, 9'h174},
        '{9'h01C, 9'h01B, 9'h01E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034}
    };

endpackage

// File: rtl/kbd_scan_decoder.sv
// Scan-code prefix decoder: turns the byte stream into one-cycle make/break
// events, skips the Pause sequence and abandons stale prefixes after a timeout.
module kbd_scan_decoder
    import kbd_map_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       flush_i,
    output logic       evt_valid_o,
    output logic       evt_break_o,
    output logic       evt_ext_o,
    output logic [7:0] evt_code_o
);

    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

    dec_state_e    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    // Events are combinational so the held register sees them on the strobe edge
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tmo_d       = '0;
        evt_valid_o = 1'b0;
        evt_break_o = 1'b0;
        evt_ext_o   = 1'b0;
        evt_code_o  = data_i;
        if (flush_i) begin
            state_d = ST_IDLE;
            skip_d  = '0;
        end else if (valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_i == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (data_i == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (data_i == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_SKIP;
                    end else begin
                        evt_valid_o = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (data_i == SC_BRK) begin
                        state_d = ST_EXTBRK;
                    end else if (data_i != SC_EXT) begin
                        evt_valid_o = 1'b1;
                        evt_ext_o   = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    evt_valid_o = 1'b1;
                    evt_break_o = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_EXTBRK: begin
                    evt_valid_o = 1'b1;
                    evt_break_o = 1'b1;
                    evt_ext_o   = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        skip_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                skip_d  = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kbd_joystick_map.sv
// PS/2 keyboard to per-player joystick words with SOCD neutralisation and flush.
// Optional autofire on fire1 is enabled by defining KBD_AUTOFIRE_EN.
module kbd_joystick_map
    import kbd_map_pkg::*;
#(
    parameter int PLAYERS        = 2,
    parameter int PREFIX_TIMEOUT = 65536,
    parameter int AF_HALF        = 400000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             kbd_data,
    input  logic                   kbd_valid,
    input  logic                   flush,
    input  logic [PLAYERS-1:0]     af_on,
    output logic [8*PLAYERS-1:0]   joy
);

    logic       evtValid, evtBreak, evtExt;
    logic [7:0] evtCode;

    logic [8*PLAYERS-1:0] held_q, held_d;
    logic [8*PLAYERS-1:0] joy_q, joy_d;
    logic [7:0]           word;

    kbd_scan_decoder #(
        .PREFIX_TIMEOUT(PREFIX_TIMEOUT)
    ) u_decoder (
        .clk         (clk),
        .reset       (reset),
        .data_i      (kbd_data),
        .valid_i     (kbd_valid),
        .flush_i     (flush),
        .evt_valid_o (evtValid),
        .evt_break_o (evtBreak),
        .evt_ext_o   (evtExt),
        .evt_code_o  (evtCode)
    );

`ifdef KBD_AUTOFIRE_EN
    localparam int AW = (AF_HALF > 2) ? $clog2(AF_HALF) : 1;

    logic [AW-1:0] afCnt_q;
    logic          afPhase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            afCnt_q   <= '0;
            afPhase_q <= 1'b0;
        end else if (afCnt_q == AW'(AF_HALF - 1)) begin
            afCnt_q   <= '0;
            afPhase_q <= ~afPhase_q;
        end else begin
            afCnt_q   <= afCnt_q + 1'b1;
        end
    end
`else
    logic afUnused;
    assign afUnused = ^af_on;
`endif

    always_comb begin
        held_d = held_q;
        if (flush) begin
            held_d = '0;
        end else if (evtValid) begin
            for (int p = 0; p < PLAYERS; p++) begin
                for (int b = 0; b < 8; b++) begin
                    if ({evtExt, evtCode} == KEY_TABLE[p][b]) begin
                        held_d[8*p+b] = ~evtBreak;
                    end
                end
            end
        end
    end

    // Raw held bits stay intact; opposing pairs are only masked on the way out
    always_comb begin
        joy_d = '0;
        word  = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            word = held_d[8*p +: 8];
            if (word[UP] && word[DOWN]) begin
                word[UP]   = 1'b0;
                word[DOWN] = 1'b0;
            end
            if (word[LEFT] && word[RIGHT]) begin
                word[LEFT]  = 1'b0;
                word[RIGHT] = 1'b0;
            end
`ifdef KBD_AUTOFIRE_EN
            if (af_on[p]) begin
                word[FIRE1] = word[FIRE1] & afPhase_q;
            end
`endif
            joy_d[8*p +: 8] = word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q <= '0;
            joy_q  <= '0;
        end else begin
            held_q <= held_d;
            joy_q  <= joy_d;
        end
    end

    assign joy = joy_q;

endmodule

// File: tb/tb_kbd_joystick_map.sv
// Self-checking bench for kbd_joystick_map (two players, short prefix timeout).
// Expected joystick words are queued when a byte is driven and checked after the edge.
module tb_kbd_joystick_map;

    localparam int PLAYERS = 2;
    localparam int TMO     = 16;
    localparam int AFH     = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           kbd_data;
    logic                 kbd_valid;
    logic                 flush;
    logic [PLAYERS-1:0]   af_on;
    logic [8*PLAYERS-1:0] joy;

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        flush;
        logic [15:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        string       name;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sbq[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int unsigned edgeCnt;

    kbd_joystick_map #(
        .PLAYERS        (PLAYERS),
        .PREFIX_TIMEOUT (TMO),
        .AF_HALF        (AFH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .flush     (flush),
        .af_on     (af_on),
        .joy       (joy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) edgeCnt <= 0;
        else       edgeCnt <= edgeCnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic void addVec(logic [7:0] d, logic v, logic f, logic [15:0] e, string n);
        vec_t x;
        x.data = d; x.valid = v; x.flush = f; x.exp = e; x.name = n;
        vecs.push_back(x);
    endfunction

    task automatic checkOutput();
        sb_t e;
        if (sbq.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sbq.pop_front();
        testsRun++;
        if (joy !== e.exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: joy=%h required %h", e.name, joy, e.exp);
        end
    endtask

    task automatic pushExp(logic [15:0] e, string n);
        sb_t s;
        s.exp = e; s.name = n;
        sbq.push_back(s);
    endtask

    task automatic applyStimulus(logic [7:0] d, logic v, logic f, logic [15:0] e, string n);
        @(negedge clk);
        kbd_data  = d;
        kbd_valid = v;
        flush     = f;
        pushExp(e, n);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idleCycles(int n, logic [15:0] e, string name);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, e, name);
    endtask

    task automatic resetDut();
        @(negedge clk);
        kbd_valid = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        #2;
        pushExp(16'h0000, "reset_state");
        checkOutput();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        kbd_data  = 8'h00;
        kbd_valid = 1'b0;
        flush     = 1'b0;
        af_on     = '0;
        repeat (3) @(posedge clk);
        resetDut();

        addVec(8'h29, 1, 0, 16'h0001, "p1_fire1_make");
        addVec(8'hF0, 1, 0, 16'h0001, "brk_prefix_hold");
        addVec(8'h29, 1, 0, 16'h0000, "p1_fire1_break");
        addVec(8'hE0, 1, 0, 16'h0000, "ext_prefix");
        addVec(8'h75, 1, 0, 16'h0010, "p1_up_make");
        addVec(8'h2D, 1, 0, 16'h1010, "p2_up_make");
        addVec(8'hE0, 1, 0, 16'h1010, "ext_brk_e0");
        addVec(8'hF0, 1, 0, 16'h1010, "ext_brk_f0");
        addVec(8'h75, 1, 0, 16'h1000, "p1_up_break");
        addVec(8'hF0, 1, 0, 16'h1000, "p2_brk_prefix");
        addVec(8'h2D, 1, 0, 16'h0000, "p2_up_break");
        addVec(8'hE0, 1, 0, 16'h0000, "left_e0");
        addVec(8'h6B, 1, 0, 16'h0040, "p1_left_make");
        addVec(8'hE0, 1, 0, 16'h0040, "right_e0");
        addVec(8'h74, 1, 0, 16'h0000, "socd_left_right");
        addVec(8'hE0, 1, 0, 16'h0000, "left_brk_e0");
        addVec(8'hF0, 1, 0, 16'h0000, "left_brk_f0");
        addVec(8'h6B, 1, 0, 16'h0080, "socd_restore_right");
        addVec(8'hE0, 1, 0, 16'h0080, "right_brk_e0");
        addVec(8'hF0, 1, 0, 16'h0080, "right_brk_f0");
        addVec(8'h74, 1, 0, 16'h0000, "p1_right_break");
        addVec(8'h16, 1, 0, 16'h0004, "start_make");
        addVec(8'h16, 1, 0, 16'h0004, "start_typematic");
        addVec(8'hF0, 1, 0, 16'h0004, "start_brk_f0");
        addVec(8'h16, 1, 0, 16'h0000, "start_break");
        addVec(8'h29, 1, 0, 16'h0001, "fire1_hold");
        addVec(8'hE1, 1, 0, 16'h0001, "pause_0");
        addVec(8'h14, 1, 0, 16'h0001, "pause_1");
        addVec(8'h77, 1, 0, 16'h0001, "pause_2");
        addVec(8'hE1, 1, 0, 16'h0001, "pause_3");
        addVec(8'hF0, 1, 0, 16'h0001, "pause_4");
        addVec(8'h14, 1, 0, 16'h0001, "pause_5");
        addVec(8'hF0, 1, 0, 16'h0001, "pause_6");
        addVec(8'h77, 1, 0, 16'h0001, "pause_7");
        addVec(8'h16, 1, 0, 16'h0005, "after_pause_start");
        addVec(8'h2D, 1, 0, 16'h1005, "p2_up_make2");
        addVec(8'h2B, 1, 0, 16'h0005, "socd_p2_up_down");
        addVec(8'hF0, 1, 0, 16'h0005, "p2_up_brk_f0");
        addVec(8'h2D, 1, 0, 16'h2005, "socd_restore_down");
        addVec(8'hF0, 1, 0, 16'h2005, "p2_down_brk_f0");
        addVec(8'h2B, 1, 0, 16'h0005, "p2_down_break");
        addVec(8'hE0, 1, 0, 16'h0005, "unmapped_e0");
        addVec(8'h1C, 1, 0, 16'h0005, "unmapped_ext_make");
        addVec(8'hF0, 1, 0, 16'h0005, "prefix_cleared_f0");
        addVec(8'h16, 1, 0, 16'h0001, "prefix_cleared_brk");

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].data, vecs[i].valid, vecs[i].flush, vecs[i].exp, vecs[i].name);
        end

        // A byte on the last counted cycle is still decoded as a break
        applyStimulus(8'hF0, 1, 0, 16'h0001, "tmo_edge_f0");
        idleCycles(TMO - 1, 16'h0001, "tmo_edge_idle");
        applyStimulus(8'h29, 1, 0, 16'h0000, "tmo_edge_break");

        applyStimulus(8'hF0, 1, 0, 16'h0000, "tmo_f0");
        idleCycles(TMO, 16'h0000, "tmo_idle");
        applyStimulus(8'h29, 1, 0, 16'h0001, "tmo_make_after");

        applyStimulus(8'h2D, 1, 0, 16'h1001, "flush_setup");
        applyStimulus(8'h16, 1, 1, 16'h0000, "flush_wins");
        idleCycles(1, 16'h0000, "flush_start_dropped");
        applyStimulus(8'hF0, 1, 0, 16'h0000, "flush_prefix_f0");
        applyStimulus(8'h00, 0, 1, 16'h0000, "flush_only");
        applyStimulus(8'h29, 1, 0, 16'h0001, "flush_forces_idle");

        applyStimulus(8'hF0, 1, 0, 16'h0001, "reset_mid_f0");
        resetDut();
        applyStimulus(8'h29, 1, 0, 16'h0001, "reset_abandons_prefix");

`ifdef KBD_AUTOFIRE_EN
        @(negedge clk);
        af_on = 2'b01;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            pushExp({15'd0, 1'(((edgeCnt - 1) / AFH) % 2)}, "autofire_phase");
            checkOutput();
        end
        @(negedge clk);
        af_on = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
